// File: rtl/sram_arb_pkg.sv
// Shared constants for the SRAM port arbiter: response-owner encodings
// and the read encoding of the byte write enables.
package sram_arb_pkg;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_INST = 2'd1;
  localparam logic [1:0] OWN_DATA = 2'd2;

  localparam logic [3:0] WEN_READ = 4'b0000;

endpackage

// File: rtl/sram_port_arbiter_starve_counter.sv
// Saturating count of consecutive cycles in which a pending fetch was
// denied; raises force_inst once the count reaches STARVE_MAX.
module starve_counter #(
  parameter int STARVE_MAX = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic inst_req,
  input  logic inst_gnt,
  output logic force_inst
);

  localparam logic [3:0] CNT_MAX = 4'(STARVE_MAX);

  logic [3:0] cnt;

  // Count denied fetch cycles, saturate at the limit, clear on grant or idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (inst_req && !inst_gnt) begin
      if (cnt != CNT_MAX) cnt <= cnt + 4'd1;
    end else begin
      cnt <= '0;
    end
  end

  assign force_inst = (cnt == CNT_MAX);

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-port synchronous SRAM between instruction fetch and
// load/store. Data wins by default; a starving fetch is forced through.
// Read data returns one cycle after the grant and is steered by owner.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_gnt,
  output logic              inst_rvalid,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic [3:0]        data_wen,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_gnt,
  output logic              data_rvalid,
  output logic [DATA_W-1:0] data_rdata,
  output logic              sram_en,
  output logic [3:0]        sram_wen,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  logic       force_inst;
  logic [1:0] resp_owner;

  starve_counter #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .clk       (clk),
    .rst       (rst),
    .inst_req  (inst_req),
    .inst_gnt  (inst_gnt),
    .force_inst(force_inst)
  );

  // Grant decision from registered state and current requests only.
  always_comb begin
    inst_gnt = inst_req & (~data_req | force_inst);
    data_gnt = data_req & ~inst_gnt;
  end

  // Drive the SRAM port from the winner; zero the fields when idle.
  always_comb begin
    sram_en    = inst_gnt | data_gnt;
    sram_wen   = '0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (inst_gnt) begin
      sram_addr = inst_addr;
    end else if (data_gnt) begin
      sram_wen   = data_wen;
      sram_addr  = data_addr;
      sram_wdata = data_wdata;
    end
  end

  // Remember who owns the read returning next cycle; stores return nothing.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_owner <= OWN_NONE;
    end else if (inst_gnt) begin
      resp_owner <= OWN_INST;
    end else if (data_gnt && (data_wen == WEN_READ)) begin
      resp_owner <= OWN_DATA;
    end else begin
      resp_owner <= OWN_NONE;
    end
  end

  assign inst_rvalid = (resp_owner == OWN_INST);
  assign data_rvalid = (resp_owner == OWN_DATA);
  assign inst_rdata  = sram_rdata;
  assign data_rdata  = sram_rdata;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a behavioural SRAM model.
module tb_sram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_gnt;
  logic        inst_rvalid;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic [3:0]  data_wen;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_gnt;
  logic        data_rvalid;
  logic [31:0] data_rdata;
  logic        sram_en;
  logic [3:0]  sram_wen;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sram_port_arbiter #(
    .ADDR_W(32),
    .DATA_W(32),
    .STARVE_MAX(3)
  ) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_gnt(inst_gnt),
    .inst_rvalid(inst_rvalid), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_gnt(data_gnt),
    .data_rvalid(data_rvalid), .data_rdata(data_rdata),
    .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  // SRAM model: 4K words indexed by addr[13:2], word i preset to A50000ii.
  logic [31:0] mem [0:4095];
  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'hA500_0000 | 32'(i);
    mem[0] = 32'h2408_0001;
    sram_rdata = '0;
  end
  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_wen == 4'b0000) begin
        sram_rdata <= mem[sram_addr[13:2]];
      end else begin
        for (int b = 0; b < 4; b++)
          if (sram_wen[b]) mem[sram_addr[13:2]][b*8 +: 8] <= sram_wdata[b*8 +: 8];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    inst_req = 0; inst_addr = '0;
    data_req = 0; data_wen = '0; data_addr = '0; data_wdata = '0;
  endtask

  initial begin
    rst = 1;
    idle();
    tick(); tick();
    chk("rst_inst_rvalid", {31'd0, inst_rvalid}, 0);
    chk("rst_data_rvalid", {31'd0, data_rvalid}, 0);
    chk("rst_cnt", {28'd0, dut.u_starve.cnt}, 0);
    chk("rst_owner", {30'd0, dut.resp_owner}, 0);
    chk("idle_en", {31'd0, sram_en}, 0);
    rst = 0;
    tick();

    // Fetch only
    inst_req = 1; inst_addr = 32'hbfc0_0000;
    #1;
    chk("if_gnt", {31'd0, inst_gnt}, 1);
    chk("if_dgnt", {31'd0, data_gnt}, 0);
    chk("if_en", {31'd0, sram_en}, 1);
    chk("if_wen", {28'd0, sram_wen}, 0);
    chk("if_addr", sram_addr, 32'hbfc0_0000);
    tick();
    idle();
    chk("if_rvalid", {31'd0, inst_rvalid}, 1);
    chk("if_rdata", inst_rdata, 32'h2408_0001);
    chk("if_drvalid", {31'd0, data_rvalid}, 0);

    // Contention: data wins 3 cycles, then fetch is forced
    inst_req = 1; inst_addr = 32'hbfc0_0000;
    data_req = 1; data_wen = 4'b0000; data_addr = 32'h0000_1004;
    for (int c = 0; c < 8; c++) begin
      #1;
      chk("st_cnt", {28'd0, dut.u_starve.cnt}, 32'(c % 4));
      chk("st_igt", {31'd0, inst_gnt}, (c % 4 == 3) ? 1 : 0);
      chk("st_dgt", {31'd0, data_gnt}, (c % 4 == 3) ? 0 : 1);
      tick();
      if (c % 4 == 3) begin
        chk("st_irv", {31'd0, inst_rvalid}, 1);
        chk("st_ird", inst_rdata, 32'h2408_0001);
      end else begin
        chk("st_drv", {31'd0, data_rvalid}, 1);
        chk("st_drd", data_rdata, 32'hA500_0401);
      end
    end
    chk("st_cnt_end", {28'd0, dut.u_starve.cnt}, 0);
    idle();

    // Partial store then read-back
    data_req = 1; data_wen = 4'b0011; data_addr = 32'h0000_1000; data_wdata = 32'hdead_beef;
    #1;
    chk("wr_gnt", {31'd0, data_gnt}, 1);
    chk("wr_wen", {28'd0, sram_wen}, 32'h3);
    chk("wr_wdata", sram_wdata, 32'hdead_beef);
    chk("wr_addr", sram_addr, 32'h0000_1000);
    tick();
    chk("wr_no_drv", {31'd0, data_rvalid}, 0);
    chk("wr_no_irv", {31'd0, inst_rvalid}, 0);
    data_wen = 4'b0000; data_wdata = '0;
    #1;
    chk("rb_wdata0", sram_wdata, 0);
    tick();
    idle();
    chk("rb_drv", {31'd0, data_rvalid}, 1);
    chk("rb_data", data_rdata, 32'hA500_BEEF);
    #1;
    chk("nog_addr", sram_addr, 0);
    chk("nog_wen", {28'd0, sram_wen}, 0);
    chk("nog_wdata", sram_wdata, 0);
    chk("nog_en", {31'd0, sram_en}, 0);

    // Alternating fetch / load, no bubbles
    for (int c = 0; c < 6; c++) begin
      idle();
      if (c % 2 == 0) begin
        inst_req = 1; inst_addr = 32'hbfc0_0000;
      end else begin
        data_req = 1; data_addr = 32'h0000_1004;
      end
      tick();
      chk("alt_irv", {31'd0, inst_rvalid}, (c % 2 == 0) ? 1 : 0);
      chk("alt_drv", {31'd0, data_rvalid}, (c % 2 == 0) ? 0 : 1);
      chk("alt_rd", inst_rdata, (c % 2 == 0) ? 32'h2408_0001 : 32'hA500_0401);
    end
    idle();

    // Build up starvation, then reset on the cycle a fetch is granted
    inst_req = 1; inst_addr = 32'hbfc0_0000;
    data_req = 1; data_addr = 32'h0000_1004;
    tick(); tick();
    chk("pre_rst_cnt", {28'd0, dut.u_starve.cnt}, 2);
    data_req = 0;
    rst = 1;
    #1;
    chk("rst_gnt_rule", {31'd0, inst_gnt}, 1);
    tick();
    chk("rst_no_irv", {31'd0, inst_rvalid}, 0);
    chk("rst_cnt2", {28'd0, dut.u_starve.cnt}, 0);
    chk("rst_owner2", {30'd0, dut.resp_owner}, 0);
    rst = 0;

    // Fetch alone for 10 cycles never starves
    for (int c = 0; c < 10; c++) begin
      #1;
      chk("solo_gnt", {31'd0, inst_gnt}, 1);
      chk("solo_cnt", {28'd0, dut.u_starve.cnt}, 0);
      tick();
    end
    idle();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one synchronous single-port SRAM between the instruction-fetch requester and the load/store (data) requester.
- Each cycle it grants at most one request and drives the SRAM port from the winner.
- It tracks which requester owns the outstanding read and steers the 1-cycle-late read data back to that requester.
- Data has default priority. A starvation counter forces an instruction grant after STARVE_MAX consecutive denied fetch cycles.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; must be 32 (byte-enable width is 4).
- STARVE_MAX, 3, consecutive denied inst cycles before inst gets forced priority; legal range 1..15.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- inst_req  in  1  fetch request; held with inst_addr stable until inst_gnt.
- inst_addr  in  ADDR_W  fetch address.
- inst_gnt  out  1  fetch accepted this cycle (combinational).
- inst_rvalid  out  1  inst_rdata valid; registered, 1 cycle after the accepting cycle.
- inst_rdata  out  DATA_W  fetch data.
- data_req  in  1  load/store request; held with all fields stable until data_gnt.
- data_wen  in  4  byte write enables; 4'b0000 means read.
- data_addr  in  ADDR_W  data address.
- data_wdata  in  DATA_W  store data.
- data_gnt  out  1  data access accepted this cycle (combinational).
- data_rvalid  out  1  data_rdata valid (reads only); registered.
- data_rdata  out  DATA_W  load data.
- sram_en  out  1  SRAM access enable.
- sram_wen  out  4  SRAM byte write enables.
- sram_addr  out  ADDR_W  SRAM address.
- sram_wdata  out  DATA_W  SRAM write data.
- sram_rdata  in  DATA_W  SRAM read data, valid the cycle after an enabled read.

Behaviour:
- Grant (combinational, registered state only):
  - force = (starve_cnt == STARVE_MAX).
  - inst_gnt = inst_req & (~data_req | force).
  - data_gnt = data_req & ~inst_gnt.
  - inst_gnt and data_gnt are never both 1.
- SRAM drive:
  - sram_en = inst_gnt | data_gnt.
  - On inst grant: sram_wen=0, sram_addr=inst_addr, sram_wdata=0.
  - On data grant: pass data_wen, data_addr, data_wdata.
  - With no grant: sram_wen, sram_addr, sram_wdata are all 0.
- Starvation counter (starve_cnt, 4 bits, reset 0):
  - If inst_req & ~inst_gnt: increment, saturating at STARVE_MAX.
  - Otherwise (inst granted, or inst_req low): clear to 0.
- Response owner register resp_owner, states NONE/INST/DATA, reset NONE:
  - Next state is INST on an inst grant.
  - Next state is DATA on a data grant with data_wen==0.
  - Next state is NONE otherwise, including data writes.
- Response outputs:
  - inst_rvalid = (resp_owner==INST); data_rvalid = (resp_owner==DATA).
  - inst_rdata and data_rdata both pass sram_rdata through; consumers qualify with rvalid.
- Throughput and latency:
  - Back-to-back grants allowed: one access per cycle, no bubbles.
  - Read latency is exactly 1 cycle from the grant cycle.
- Writes: no rvalid; the grant cycle completes the store.
- Simultaneous requests:
  - Data wins unless force=1.
  - When force=1 inst wins, data_gnt=0, and data must hold its request.
- Reset:
  - rst=1 clears starve_cnt and resp_owner at the edge.
  - A read granted in the cycle rst is sampled produces no rvalid.
  - While rst=1: all rvalid outputs are 0 (registered) and grants still follow the combinational rule. Requesters are held off by their own reset.
- Arbiter does not check address alignment; sram_addr is passed unmodified.

Decomposition:
- Shared package sram_arb_pkg:
  - resp_owner encoding constants OWN_NONE=2'd0, OWN_INST=2'd1, OWN_DATA=2'd2.
  - WEN_READ=4'b0000.
- One natural sub-module: starve_counter (saturating counter, outputs force).
- Grant, mux and response logic stay in the top level.

Test Plan:
- Only inst_req=1, addr 0xbfc00000; SRAM model returns 0x24080001 -> inst_gnt=1 same cycle, sram_en=1, sram_wen=0; next cycle inst_rvalid=1, inst_rdata=0x24080001, data_rvalid=0.
- Both req every cycle, data reads, STARVE_MAX=3 -> data granted cycles 0,1,2, inst granted cycle 3, starve_cnt returns 0; pattern repeats with period 4.
- data store wen=4'b0011, addr 0x1000, wdata 0xdeadbeef -> sram_wen=0011, sram_wdata=0xdeadbeef; no data_rvalid next cycle; read back 0x1000 -> data_rvalid=1 one cycle after grant.
- Alternating inst read and data read on consecutive cycles -> rvalid toggles each cycle to the correct owner, no bubbles, no cross-delivery.
- Inst read granted, rst=1 next edge -> inst_rvalid stays 0, starve_cnt=0, resp_owner=NONE.
- inst_req=1 with data_req=0 for 10 cycles -> starve_cnt stays 0 and inst_gnt=1 every cycle.
